shiftregv: RTL and testbench

Runtime-selectable parallel delay line with per-stage valid tracking. Generalises the fixed-depth parallel shift register: delay selected per cycle (0..DEPTH) without re-synthesis, a valid bit travels with every word, a flush clears in-flight validity, and a fill counter reports priming. Used in alignment paths where channel skew is calibrated at run time.

---
 rtl/shiftregv.sv | 133 +++++++++++++
 tb/tb_shiftregv.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/shiftregv.sv
// shiftregv: runtime-selectable parallel delay line with per-stage valid bits.
//
// Stages 1..DEPTH each hold a WIDTH-bit word plus a valid bit. On every
// enabled clock the input word enters stage 1 and every stage moves one
// position down. The word and valid bit at the selected delay appear on
// delay/out_valid. The selected delay is clamped to DEPTH, and a delay of 0
// passes the input straight through.
//
// Optional build macro:
//   SHIFTREGV_OUTREG_EN  when defined, delay/out_valid are registered on
//                        every clk edge, whatever the value of ena. This adds
//                        one clk of latency. Flush also clears the registered
//                        out_valid. Both registered outputs reset to 0.
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   ena        shift enable; when low, the chain holds its contents
//   flush      synchronous clear of all valid bits and of the fill counter
//   in_valid   qualifies data
//   data       input word
//   sel        runtime delay in enabled shifts; values above DEPTH clamp
//   delay      word at the selected delay
//   out_valid  valid bit that goes with delay
//   taps       all stages; slice 0 = data, slice k = stage k
//   fill       enabled shifts since reset/flush; saturates at DEPTH
//   primed     fill >= clamped sel
module shiftregv #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned SELW = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           data,
  input  logic [SELW-1:0]            sel,
  output logic [WIDTH-1:0]           delay,
  output logic                       out_valid,
  output logic [WIDTH*(DEPTH+1)-1:0] taps,
  output logic [SELW-1:0]            fill,
  output logic                       primed
);

  if (WIDTH < 1) begin : g_bad_width
    $error("shiftregv: WIDTH must be >= 1");
  end
  if (DEPTH < 1) begin : g_bad_depth
    $error("shiftregv: DEPTH must be >= 1");
  end

  logic [DEPTH:1][WIDTH-1:0] word;
  logic [DEPTH:1]            vld;
  logic [SELW-1:0]           fill_q;
  logic [SELW-1:0]           sel_c;
  logic [WIDTH-1:0]          mux_word;
  logic                      mux_vld;

  // Shift chain and fill counter. A flush overrides the valid bit that is
  // being shifted into stage 1 in the same cycle, but the data words still move.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word   <= '0;
      vld    <= '0;
      fill_q <= '0;
    end else begin
      if (ena) begin
        word[1] <= data;
        vld[1]  <= in_valid;
        for (int unsigned k = 2; k <= DEPTH; k++) begin
          word[k] <= word[k-1];
          vld[k]  <= vld[k-1];
        end
      end
      if (flush) begin
        vld    <= '0;
        fill_q <= '0;
      end else if (ena && (fill_q != SELW'(DEPTH))) begin
        fill_q <= fill_q + 1'b1;
      end
    end
  end

  always_comb begin
    sel_c = (sel > SELW'(DEPTH)) ? SELW'(DEPTH) : sel;
  end

  // Output mux. A clamped delay of 0 keeps the default, which is the
  // combinational pass-through of data/in_valid.
  always_comb begin
    mux_word = data;
    mux_vld  = in_valid;
    for (int unsigned k = 1; k <= DEPTH; k++) begin
      if (sel_c == SELW'(k)) begin
        mux_word = word[k];
        mux_vld  = vld[k];
      end
    end
  end

  always_comb begin
    taps = '0;
    taps[WIDTH-1:0] = data;
    for (int unsigned k = 1; k <= DEPTH; k++) begin
      taps[k*WIDTH +: WIDTH] = word[k];
    end
  end

  always_comb begin
    fill   = fill_q;
    primed = (fill_q >= sel_c);
  end

`ifdef SHIFTREGV_OUTREG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      delay     <= '0;
      out_valid <= 1'b0;
    end else begin
      delay     <= mux_word;
      out_valid <= mux_vld & ~flush;
    end
  end
`else
  always_comb begin
    delay     = mux_word;
    out_valid = mux_vld;
  end
`endif

endmodule

// File: tb/tb_shiftregv.sv
module tb_shiftregv;

  localparam int W  = 16;
  localparam int D  = 8;
  localparam int SW = 4;
  localparam int TW = W * (D + 1);

  logic          clk;
  logic          rst_n;
  logic          ena;
  logic          flush;
  logic          in_valid;
  logic [W-1:0]  data;
  logic [SW-1:0] sel;
  logic [W-1:0]  delay;
  logic          out_valid;
  logic [TW-1:0] taps;
  logic [SW-1:0] fill;
  logic          primed;

  shiftregv #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .flush(flush), .in_valid(in_valid),
    .data(data), .sel(sel), .delay(delay), .out_valid(out_valid),
    .taps(taps), .fill(fill), .primed(primed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: history of accepted words, newest first. Entry i is the word
  // accepted i+1 enabled edges ago.
  typedef struct {
    logic [W-1:0] d;
    logic         v;
  } ent_t;

  ent_t         hist[$];
  int           mfill;
  logic [W-1:0] rd;
  logic         rv;

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < D; i++) hist.push_back('{d: '0, v: 1'b0});
    mfill = 0;
    rd = '0;
    rv = 1'b0;
  endtask

  function automatic int selc();
    return (int'(sel) > D) ? D : int'(sel);
  endfunction

  task automatic comb_out(output logic [W-1:0] ed, output logic ev);
    int s = selc();
    if (s == 0) begin
      ed = data;
      ev = in_valid;
    end else begin
      ed = hist[s-1].d;
      ev = hist[s-1].v;
    end
  endtask

  task automatic chk(input string nm, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [W-1:0]  ed;
    logic          ev;
    logic [TW-1:0] et;
    comb_out(ed, ev);
`ifdef SHIFTREGV_OUTREG_EN
    ed = rd;
    ev = rv;
`endif
    et = '0;
    et[W-1:0] = data;
    for (int k = 1; k <= D; k++) et[k*W +: W] = hist[k-1].d;
    chk({tag, "/delay"}, TW'(delay), TW'(ed));
    chk({tag, "/out_valid"}, TW'(out_valid), TW'(ev));
    chk({tag, "/taps"}, taps, et);
    chk({tag, "/fill"}, TW'(fill), TW'(mfill));
    chk({tag, "/primed"}, TW'(primed), TW'(mfill >= selc()));
  endtask

  // One clock: the reference consumes the inputs that were stable at the edge,
  // then outputs are sampled 1 time unit later.
  task automatic tick();
    logic [W-1:0] cd;
    logic         cv;
    @(posedge clk);
    if (rst_n) begin
      comb_out(cd, cv);
      rd = cd;
      rv = cv & ~flush;
      if (ena) begin
        hist.push_front('{d: data, v: in_valid & ~flush});
        void'(hist.pop_back());
      end
      if (flush) begin
        foreach (hist[i]) hist[i].v = 1'b0;
        mfill = 0;
      end else if (ena && mfill < D) begin
        mfill++;
      end
    end
    #1;
  endtask

  typedef struct {
    logic          ena;
    logic          fl;
    logic          iv;
    logic [W-1:0]  d;
    logic [SW-1:0] s;
    logic [W-1:0]  ed;
    logic          ev;
    logic [SW-1:0] ef;
    logic          ep;
  } vec_t;

  vec_t vec[13];

  initial begin
    //              ena   fl    iv    data      sel    exp delay exp v fill   primed
    vec[0]  = '{1'b1, 1'b0, 1'b1, 16'h0001, 4'd3,  16'h0000, 1'b0, 4'd1, 1'b0};
    vec[1]  = '{1'b1, 1'b0, 1'b1, 16'h0002, 4'd3,  16'h0000, 1'b0, 4'd2, 1'b0};
    vec[2]  = '{1'b1, 1'b0, 1'b1, 16'h0003, 4'd3,  16'h0001, 1'b1, 4'd3, 1'b1};
    vec[3]  = '{1'b1, 1'b0, 1'b1, 16'h0004, 4'd3,  16'h0002, 1'b1, 4'd4, 1'b1};
    vec[4]  = '{1'b0, 1'b0, 1'b1, 16'h00AA, 4'd0,  16'h00AA, 1'b1, 4'd4, 1'b1};
    vec[5]  = '{1'b1, 1'b0, 1'b1, 16'h00AA, 4'd2,  16'h0004, 1'b1, 4'd5, 1'b1};
    vec[6]  = '{1'b0, 1'b0, 1'b0, 16'h0055, 4'd2,  16'h0004, 1'b1, 4'd5, 1'b1};
    vec[7]  = '{1'b1, 1'b0, 1'b0, 16'h0055, 4'd2,  16'h00AA, 1'b1, 4'd6, 1'b1};
    vec[8]  = '{1'b0, 1'b0, 1'b0, 16'h0055, 4'd2,  16'h00AA, 1'b1, 4'd6, 1'b1};
    vec[9]  = '{1'b1, 1'b1, 1'b1, 16'h0077, 4'd4,  16'h0004, 1'b0, 4'd0, 1'b0};
    vec[10] = '{1'b1, 1'b0, 1'b1, 16'h0088, 4'd4,  16'h00AA, 1'b0, 4'd1, 1'b0};
    vec[11] = '{1'b0, 1'b0, 1'b1, 16'h0099, 4'd15, 16'h0001, 1'b0, 4'd1, 1'b0};
    vec[12] = '{1'b0, 1'b0, 1'b1, 16'h0099, 4'd1,  16'h0088, 1'b1, 4'd1, 1'b1};

    rst_n = 1'b0; ena = 1'b0; flush = 1'b0; in_valid = 1'b0;
    data = '0; sel = 4'd3;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset/delay", TW'(delay), '0);
    chk("reset/out_valid", TW'(out_valid), '0);
    chk("reset/fill", TW'(fill), '0);
    chk("reset/primed", TW'(primed), '0);
    check_model("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      ena = vec[i].ena; flush = vec[i].fl; in_valid = vec[i].iv;
      data = vec[i].d; sel = vec[i].s;
      tick();
`ifndef SHIFTREGV_OUTREG_EN
      chk($sformatf("vec%0d/delay", i), TW'(delay), TW'(vec[i].ed));
      chk($sformatf("vec%0d/out_valid", i), TW'(out_valid), TW'(vec[i].ev));
`endif
      chk($sformatf("vec%0d/fill", i), TW'(fill), TW'(vec[i].ef));
      chk($sformatf("vec%0d/primed", i), TW'(primed), TW'(vec[i].ep));
      check_model($sformatf("vec%0d", i));
    end

    // Oversized sel clamps to DEPTH; fill saturates at DEPTH.
    sel = 4'd15; ena = 1'b1; flush = 1'b0;
    for (int i = 0; i < 10; i++) begin
      data = W'($urandom); in_valid = 1'b1;
      tick();
      check_model("sat");
    end
    chk("sat/fill", TW'(fill), TW'(D));
    chk("sat/primed", TW'(primed), TW'(1));

    // Zero delay passes the input through without waiting for a clock.
    ena = 1'b0; sel = 4'd0; data = 16'h1234; in_valid = 1'b1;
    #1;
`ifndef SHIFTREGV_OUTREG_EN
    chk("pass/delay", TW'(delay), TW'(16'h1234));
    chk("pass/out_valid", TW'(out_valid), TW'(1));
`endif
    in_valid = 1'b0;
    #1;
`ifndef SHIFTREGV_OUTREG_EN
    chk("pass/out_valid_low", TW'(out_valid), TW'(0));
`endif
    tick();
    check_model("pass");

    for (int i = 0; i < 400; i++) begin
      ena      = ($urandom_range(0, 9) < 7);
      flush    = ($urandom_range(0, 19) == 0);
      in_valid = 1'($urandom);
      data     = W'($urandom);
      sel      = SW'($urandom_range(0, 15));
      tick();
      check_model("rnd");
    end

    // Asynchronous reset mid-stream, sampled before the next clock edge.
    sel = 4'd5; ena = 1'b1; flush = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      data = W'(16'h0100 + i);
      tick();
      check_model("prime5");
    end
    chk("prime5/out_valid", TW'(out_valid), TW'(1));
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst/delay", TW'(delay), '0);
    chk("arst/out_valid", TW'(out_valid), '0);
    chk("arst/fill", TW'(fill), '0);
    chk("arst/primed", TW'(primed), '0);
    check_model("arst");
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      data = W'(16'h0200 + i);
      tick();
      check_model("after_rst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
